// File: rtl/exc_pkg.sv
// Shared exception codes, opcode constants and the ALU overflow decode.
// Pure definitions: no state, no latency.
// Used by the status unit top and its bench-facing decode.
package exc_pkg;

    localparam int CODE_W = 3;

    typedef logic [CODE_W-1:0] exc_code_t;

    localparam exc_code_t EXC_NONE = 3'd0;
    localparam exc_code_t EXC_ADD  = 3'd1;
    localparam exc_code_t EXC_ADDI = 3'd2;
    localparam exc_code_t EXC_SUB  = 3'd3;
    localparam exc_code_t EXC_MUL  = 3'd4;
    localparam exc_code_t EXC_DIV  = 3'd5;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    // Map an overflowing ALU instruction to its status code; EXC_NONE if it
    // is not one of the instructions that can raise an overflow exception.
    function automatic exc_code_t decode_alu(input logic [4:0] opcode,
                                             input logic [4:0] aluop);
        exc_code_t code;
        code = EXC_NONE;
        if (opcode == OP_ADDI) begin
            code = EXC_ADDI;
        end else if (opcode == OP_RTYPE) begin
            if (aluop == ALU_ADD) begin
                code = EXC_ADD;
            end else if (aluop == ALU_SUB) begin
                code = EXC_SUB;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/exc_fifo_2w1r.sv
// Small FIFO with two write ports (wr0 ordered before wr1) and one read port.
// Latency 1: a write is visible at the head on the next cycle; head is from flops.
// No internal flow control: the caller guarantees writes never exceed free space.
module exc_fifo_2w1r #(
    parameter int DEPTH = 4,
    parameter int W     = 3,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr0_vld_i,
    input  logic [W-1:0]  wr0_dat_i,
    input  logic          wr1_vld_i,
    input  logic [W-1:0]  wr1_dat_i,
    input  logic          rd_rdy_i,
    output logic          rd_vld_o,
    output logic [W-1:0]  rd_dat_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;

    assign pop      = rd_rdy_i & (cnt_q != '0);
    assign rd_vld_o = (cnt_q != '0);
    // Force zero when empty so the idle output never shows a stale code.
    assign rd_dat_o = rd_vld_o ? mem_q[rptr_q] : '0;
    assign count_o  = cnt_q;

    // Next-state: storage writes, pointer advance (wraps mod DEPTH) and occupancy.
    // wr1 is only ever asserted together with wr0, so it lands one slot later.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr0_vld_i) begin
                mem_d[wptr_q] = wr0_dat_i;
            end
            if (wr1_vld_i) begin
                mem_d[wptr_q + PW'(1)] = wr1_dat_i;
            end
            wptr_d = wptr_q + PW'(wr0_vld_i) + PW'(wr1_vld_i);
            rptr_d = rptr_q + PW'(pop);
            cnt_d  = cnt_q + CW'(wr0_vld_i) + CW'(wr1_vld_i) - CW'(pop);
        end
    end

    // State registers; asynchronous reset empties the queue immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/exc_status_unit.sv
// Decodes ALU overflow and multdiv exceptions into status codes and buffers them for $r30 writeback.
// Latency 1 from event to wb_valid_o when empty; outputs come straight from flops.
// wb_valid_o/wb_ready_i handshake; head held while stalled; events beyond free space are counted and dropped.
module exc_status_unit
    import exc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int STATUS_REG = 30,
    parameter int CNT_WIDTH  = 8,
    localparam int PEND_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alu_valid_i,
    input  logic                  alu_ovf_i,
    input  logic [4:0]            alu_opcode_i,
    input  logic [4:0]            alu_aluop_i,
    input  logic                  md_valid_i,
    input  logic                  md_exc_i,
    input  logic                  md_is_div_i,
    input  logic                  clear_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [4:0]            wb_addr_o,
    output logic                  exc_flag_o,
    output logic [PEND_W-1:0]     pending_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam logic [PEND_W:0] DEPTH_V = (PEND_W + 1)'(DEPTH);

    exc_code_t             alu_code;
    exc_code_t             md_code;
    exc_code_t             head_code;
    logic                  alu_ev;
    logic                  md_ev;
    logic                  pop;
    logic [PEND_W:0]       free_slots;
    logic                  acc_alu;
    logic                  acc_md;
    logic [1:0]            n_drop;
    logic                  wr0_vld;
    logic                  wr1_vld;
    exc_code_t             wr0_dat;
    logic [CNT_WIDTH:0]    drop_sum;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic                  flag_q, flag_d;

    assign alu_code = decode_alu(alu_opcode_i, alu_aluop_i);
    assign md_code  = md_is_div_i ? EXC_DIV : EXC_MUL;
    assign alu_ev   = alu_valid_i & alu_ovf_i & (alu_code != EXC_NONE);
    assign md_ev    = md_valid_i & md_exc_i;
    assign pop      = wb_valid_o & wb_ready_i;

    // Admission: a same-cycle pop frees a slot; ALU takes the first free slot, MD the next.
    always_comb begin
        free_slots = DEPTH_V - {1'b0, pending_o} + {{PEND_W{1'b0}}, pop};
        acc_alu    = alu_ev & (free_slots != '0);
        acc_md     = md_ev & (free_slots > {{PEND_W{1'b0}}, acc_alu});
        n_drop     = {1'b0, alu_ev & ~acc_alu} + {1'b0, md_ev & ~acc_md};
        // The earlier accepted event always occupies write port 0.
        wr0_vld    = ~clear_i & (acc_alu | acc_md);
        wr1_vld    = ~clear_i & acc_alu & acc_md;
        wr0_dat    = acc_alu ? alu_code : md_code;
    end

    // Drop counter and exception pulse next-state; clear wins over everything.
    always_comb begin
        drop_sum = {1'b0, drop_q} + (CNT_WIDTH + 1)'(n_drop);
        drop_d   = drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];
        flag_d   = acc_alu | acc_md;
        if (clear_i) begin
            drop_d = '0;
            flag_d = 1'b0;
        end
    end

    // Drop counter and exception pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
            flag_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
            flag_q <= flag_d;
        end
    end

    exc_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clear_i),
        .wr0_vld_i (wr0_vld),
        .wr0_dat_i (wr0_dat),
        .wr1_vld_i (wr1_vld),
        .wr1_dat_i (md_code),
        .rd_rdy_i  (wb_ready_i),
        .rd_vld_o  (wb_valid_o),
        .rd_dat_o  (head_code),
        .count_o   (pending_o)
    );

    assign wb_data_o  = {{(DATA_WIDTH - CODE_W){1'b0}}, head_code};
    assign wb_addr_o  = 5'(STATUS_REG);
    assign exc_flag_o = flag_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: doc/exc_status_unit.md
# exc_status_unit

Parametrised exception-status unit for the processor's overflow/exception path: decodes ALU overflow (add, addi, sub) and multiply/divide exceptions into status codes, queues them in a small FIFO, and drains them through a valid/ready writeback port to the status register ($r30). It sits between the execute stage (ALU and multdiv) and the register-file write arbiter. It replaces the single-cycle combinational status decode with buffered, non-lossy capture of back-to-back and simultaneous exceptions.

## Interface
- DATA_WIDTH, 32, width of the status word written back
- DEPTH, 4, FIFO entries; power of two, ≥2
- STATUS_REG, 30, register index driven on wb_addr
- CNT_WIDTH, 8, width of saturating drop counter
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- alu_valid  in  1  ALU result valid this cycle
- alu_ovf  in  1  ALU overflow flag
- alu_opcode  in  5  instruction opcode
- alu_aluop  in  5  ALU opcode field
- md_valid  in  1  multdiv result valid this cycle
- md_exc  in  1  multdiv exception (mul overflow / div by zero)
- md_is_div  in  1  1 = divide, 0 = multiply
- clear  in  1  synchronous flush of FIFO and counter
- wb_valid  out  1  head entry available
- wb_ready  in  1  writeback arbiter accepts head
- wb_data  out  DATA_WIDTH  status code, zero-extended
- wb_addr  out  5  constant STATUS_REG
- exc_flag  out  1  registered one-cycle pulse per captured exception
- pending  out  $clog2(DEPTH+1)  FIFO occupancy
- drop_cnt  out  CNT_WIDTH  saturating count of lost exceptions

## Operation
- Codes: add (opcode 00000, aluop 00000) = 1; addi (opcode 00101, aluop ignored) = 2; sub (opcode 00000, aluop 00001) = 3; mul = 4; div = 5. Any other opcode/aluop pair with alu_ovf raises no exception.
- ALU event = alu_valid & alu_ovf & decoded code ≠ 0. MD event = md_valid & md_exc.
- Up to two pushes per cycle. ALU entry is always ordered before the MD entry.
- Free slots = DEPTH − pending + (pop this cycle ? 1 : 0). A pop is wb_valid & wb_ready.
- Events are accepted in order (ALU first) while free slots remain. Each rejected event increments drop_cnt, which saturates at all-ones.
- exc_flag is 1 in the cycle after ≥1 event is accepted.
- clear empties the FIFO, zeroes drop_cnt, and discards same-cycle pushes and pops. clear has priority over all other activity.
- Reset values: wb_valid 0, wb_data 0, exc_flag 0, pending 0, drop_cnt 0. wb_addr is constant.

## Timing
- Event in cycle N with FIFO empty: wb_valid = 1 and wb_data valid in cycle N+1. Latency is 1, and the head is registered.
- wb_data and wb_valid are held stable while wb_valid & ~wb_ready.
- Full and pop in the same cycle: one push is accepted. Full with two events and a pop: ALU is accepted, MD is dropped.
- Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy tracks 0..DEPTH without aliasing.
- Reset asserted mid-drain deasserts wb_valid immediately (asynchronously). No entry survives reset.
- No combinational path from any input to wb_valid or wb_data.

## Structure
- Shared package exc_pkg holds:
  - code constants EXC_NONE=0, EXC_ADD=1, EXC_ADDI=2, EXC_SUB=3, EXC_MUL=4, EXC_DIV=5, with a 3-bit code type;
  - opcode constants OP_RTYPE=00000, OP_ADDI=00101, ALU_ADD=00000, ALU_SUB=00001.
- The FIFO stores 3-bit codes only; zero-extension to DATA_WIDTH happens at the output.
- One natural sub-module: exc_fifo_2w1r (two write ports, one read port, parametrised DEPTH and entry width).
- Decode and drop logic stay in the top level.

## Test plan
- Reset is low, then released; no events are applied. Required: all outputs read 0 and wb_addr = 30.
- sub overflow (opcode 00000, aluop 00001, alu_ovf=1) with wb_ready=1. Required: the next cycle shows wb_valid=1, wb_data=3 and an exc_flag pulse; the following cycle shows pending=0.
- Same cycle: addi overflow and a div exception, with wb_ready=0. Required: pending=2; drains in order 2 then 5.
- wb_ready=0; apply 6 add overflows with DEPTH=4. Required: pending=4, drop_cnt=2, and wb_data held at 1 throughout.
- FIFO full; apply alu and md events together with wb_ready=1. Required: the ALU event is accepted, drop_cnt increments by 1, and pending stays at 4.
- Reset (or clear) asserted with 3 entries pending. Required: pending=0 and wb_valid=0 immediately (reset) or on the next edge (clear); drop_cnt=0.
